// File: rtl/bus_pkg.sv
// Shared bus packet definitions: destination/payload layout and the broadcast id.
// Used by the FIFO, agent, checker and scoreboard.
package bus_pkg;

  localparam int unsigned PckgSz   = 20;
  localparam int unsigned DestW    = 8;
  localparam int unsigned DestMsb  = PckgSz - 1;
  localparam int unsigned DestLsb  = PckgSz - DestW;
  localparam int unsigned PayloadW = PckgSz - DestW;

  localparam logic [DestW-1:0] BcastId = 8'hFF;

  typedef struct packed {
    logic [DestW-1:0]    dest;
    logic [PayloadW-1:0] payload;
  } pkt_t;

  function automatic logic is_bcast(input pkt_t p);
    return p.dest == BcastId;
  endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// Register-array storage for the transmit FIFO: one synchronous write port and
// one asynchronous read port.
module bus_fifo_mem #(
  parameter int unsigned width = 20,
  parameter int unsigned depth = 16,
  parameter int unsigned aw    = (depth > 1) ? $clog2(depth) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [aw-1:0]    waddr,
  input  logic [width-1:0] wdata,
  input  logic [aw-1:0]    raddr,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_tx_fifo.sv
// Per-device first-word-fall-through transmit queue feeding the bus arbiter.
// Tracks occupancy and reports dropped pushes and pops seen while empty.
module bus_tx_fifo
  import bus_pkg::*;
#(
  parameter int unsigned pckg_sz  = PckgSz,
  parameter int unsigned depth    = 16,
  parameter int unsigned cnt_w    = 16,
  parameter int unsigned aful_lvl = depth - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [pckg_sz-1:0]         wr_data,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(depth+1)-1:0] count,
  input  logic                       pop,
  output logic [pckg_sz-1:0]         D_pop,
  output logic                       pndng,
  output logic [cnt_w-1:0]           ovf_cnt,
  input  logic                       pop_unused_guard = 1'b0,
  output logic                       udf_err
);

  localparam int unsigned ptr_w = $clog2(depth);
  localparam int unsigned cw    = $clog2(depth + 1);

  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(depth - 1);
  localparam logic [cw-1:0]    depth_c  = cw'(depth);
  localparam logic [cw-1:0]    aful_c   = cw'(aful_lvl);
  localparam logic [cnt_w-1:0] ovf_max  = '1;

  logic [ptr_w-1:0]   rd_ptr_q, wr_ptr_q;
  logic [cw-1:0]      count_q;
  logic [cnt_w-1:0]   ovf_cnt_q;
  logic               udf_err_q;
  logic               push_ok, pop_ok;
  logic [pckg_sz-1:0] rdata;

  // Explicit wrap so non-power-of-two depths index correctly.
  function automatic logic [ptr_w-1:0] adv(input logic [ptr_w-1:0] p);
    return (p == last_ptr) ? '0 : p + ptr_w'(1);
  endfunction

  assign pndng       = (count_q != '0);
  assign full        = (count_q == depth_c);
  assign almost_full = (count_q >= aful_c);
  assign count       = count_q;
  assign ovf_cnt     = ovf_cnt_q;
  assign udf_err     = udf_err_q;

  // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
  assign pop_ok  = pop && pndng;
  assign push_ok = wr_en && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_cnt_q <= '0;
      udf_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= adv(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= adv(rd_ptr_q);
      if (push_ok && !pop_ok)      count_q <= count_q + cw'(1);
      else if (pop_ok && !push_ok) count_q <= count_q - cw'(1);
      if (wr_en && full && !pop && (ovf_cnt_q != ovf_max)) ovf_cnt_q <= ovf_cnt_q + cnt_w'(1);
      if (pop && !pndng) udf_err_q <= 1'b1;
    end
  end

  bus_fifo_mem #(
    .width(pckg_sz),
    .depth(depth),
    .aw   (ptr_w)
  ) u_mem (
    .clk  (clk),
    .we   (push_ok && !reset),
    .waddr(wr_ptr_q),
    .wdata(wr_data),
    .raddr(rd_ptr_q),
    .rdata(rdata)
  );

  assign D_pop = pndng ? rdata : '0;

endmodule

// File: doc/bus_tx_fifo.md
Name: bus_tx_fifo

Overview:
Per-device transmit queue that sits directly upstream of bs_gnrtr_n_rbtr, one instance per driver port i.
Accepts packets from the device-side agent/driver and presents them to the bus as first-word-fall-through: pndng[i] and D_pop[i], with pop[i] returned by the bus.
Reports occupancy, overflow and underflow to the checker and scoreboard.
Packet format matches the bus: bits [pckg_sz-1:pckg_sz-8] are the destination id (broadcast = all ones), and the remaining bits are payload.

Parameters:
pckg_sz, 20, packet width in bits (≥9)
depth, 16, FIFO entries (≥2, any integer, not restricted to power of two)
cnt_w, 16, width of ovf_cnt
aful_lvl, depth-2, occupancy at or above which almost_full asserts

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  synchronous, active-high
wr_en  in  1  device push request
wr_data  in  pckg_sz  packet to enqueue
full  out  1  occupancy == depth
almost_full  out  1  occupancy >= aful_lvl
count  out  $clog2(depth+1)  current occupancy
pop  in  1  bus consumes head entry (from bs_gnrtr_n_rbtr)
D_pop  out  pckg_sz  head packet to bus
pndng  out  1  occupancy != 0
ovf_cnt  out  cnt_w  dropped-push counter, saturating
udf_err  out  1  sticky: pop seen while empty

Behaviour:
- Reset: on a clk edge with reset=1, the following clear, and any in-flight data is discarded:
  - rd_ptr, wr_ptr, count → 0
  - ovf_cnt → 0, udf_err → 0
  - full, almost_full, pndng → 0
  - D_pop → 0
- Reset has priority over wr_en and pop in the same cycle. A reset in mid-stream simply empties the queue; no partial state survives.
- Storage: depth × pckg_sz registers. Pointers wrap explicitly: ptr==depth-1 → 0 (no modulo-2^n assumption).
- Write: wr_en=1 and the write is accepted → entry stored at wr_ptr at the clk edge. pndng rises the next cycle (latency 1, edge to flag).
- Read (FWFT):
  - D_pop = mem[rd_ptr] combinationally whenever pndng=1; D_pop = 0 when empty.
  - pop=1 with pndng=1 → rd_ptr advances at the edge, and the next entry appears on D_pop the following cycle.
  - The bus may pop on consecutive cycles.
- Accept rule: push accepted iff !full OR (full AND pop). Simultaneous push+pop while full → both occur, count unchanged, no overflow.
- Overflow: wr_en=1, full=1, pop=0 → data dropped, ovf_cnt += 1. ovf_cnt saturates at 2^cnt_w-1 (no wrap).
- Underflow: pop=1 with pndng=0 → ignored, no pointer or count change. udf_err set and held until reset.
- Simultaneous push+pop while empty → the push is accepted and the pop is flagged as underflow. count becomes 1.
- Count update:
  - +1 on an accepted push alone
  - −1 on a valid pop alone
  - unchanged when both occur or neither occurs
- All flags are registered or derived from registered count; no combinational path from wr_en to full/pndng.
- Data is passed through unmodified. The FIFO does not interpret destination or broadcast bits; routing is the arbiter's job.

Decomposition:
- Shared package bus_pkg:
  - typedef for the packet struct (dest id [7:0], payload [pckg_sz-9:0])
  - broadcast id constant 8'hFF
  - localparams for the field offsets
  - These are also used by the agent, checker and scoreboard.
- One natural sub-module: bus_fifo_mem (register array + write port + async read).
- Pointer, count and flag logic stays in bus_tx_fifo.
- Top-level integration instantiates drvrs copies; the bench connects them to pndng[i]/D_pop[i]/pop[i].

Test Plan:
1. Reset then write 3 packets (0x02001, 0x03002, 0xFF003) with pop=0 → count=3, pndng=1, and D_pop=0x02001 one cycle after the first write.
2. Pop 3 times back-to-back → D_pop sequence 0x02001, 0x03002, 0xFF003, then pndng=0, D_pop=0, udf_err=0.
3. Fill to 16 → full=1, almost_full=1 from count=14. A 17th push with pop=0 → dropped, ovf_cnt=1, count=16.
4. When full, push 0x0A0AA with pop=1 in the same cycle → count stays 16, ovf_cnt unchanged, and 0x0A0AA is later popped as the 16th item.
5. Pop while empty → udf_err=1 persists across later normal traffic; count stays 0. Push+pop in the same cycle while empty → count=1.
6. Reset asserted mid-stream (count=7, ovf_cnt=2) → next cycle count=0, pndng=0, D_pop=0, ovf_cnt=0, udf_err=0. Wrap check: 40 push/pop pairs with depth=5 preserve order.
